chunked_adder: RTL

Parametrised multi-cycle adder/subtractor that computes a WIDTH-bit sum one SLICE-bit group per clock. Each slice uses the carry-lookahead equations P = A ^ B, G = A & B and C[i] = G[i] | (P[i] & C[i-1]). The inter-slice carry is held in a register. Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake. The block serves as the wide arithmetic unit for datapaths where a full-width combinational carry chain does not meet timing.

---
 rtl/chunked_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit lookahead group per clock.
// Define CHUNKED_ADDER_OVF_EN to compute the signed-overflow flag OV; otherwise OV is tied to 0.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_1,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV
);

  localparam int SLICE_SAFE = (SLICE < 1) ? 1 : SLICE;
  localparam int NSL = WIDTH / SLICE_SAFE;
  localparam int KW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [WIDTH-1:0] SL_MASK = WIDTH'({SLICE_SAFE{1'b1}});

  if ((SLICE < 1) || ((WIDTH % SLICE_SAFE) != 0)) begin : g_bad_cfg
    $error("chunked_adder: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      a_q, b_q, sum_q, sum_d, s_q;
  logic                  carry_q, co_q;
  logic [KW-1:0]         k_q;
  logic [SLICE_SAFE-1:0] a_sl, b_sl, p, g, sl_sum;
  logic                  c, sl_cout, last_slice;
  int                    base;
`ifdef CHUNKED_ADDER_OVF_EN
  logic                  msb_cin, ov_q;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready/valid come straight from the state register, never from the partner's signal.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign S          = s_q;
  assign CO         = co_q;
  assign last_slice = (k_q == KW'(NSL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Current slice: lookahead generate/propagate with the registered inter-slice carry.
  always_comb begin
    base = int'(k_q) * SLICE_SAFE;
    a_sl = SLICE_SAFE'(a_q >> base);
    b_sl = SLICE_SAFE'(b_q >> base);
    p    = a_sl ^ b_sl;
    g    = a_sl & b_sl;
    c    = carry_q;
    sl_sum = '0;
`ifdef CHUNKED_ADDER_OVF_EN
    msb_cin = 1'b0;
`endif
    for (int i = 0; i < SLICE_SAFE; i++) begin
      sl_sum[i] = p[i] ^ c;
`ifdef CHUNKED_ADDER_OVF_EN
      if (i == SLICE_SAFE - 1) msb_cin = c;
`endif
      c = g[i] | (p[i] & c);
    end
    sl_cout = c;
    sum_d   = (sum_q & ~(SL_MASK << base)) | (WIDTH'(sl_sum) << base);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ov_q    <= 1'b0;
`endif
    end else if (state_q == IDLE && in_valid) begin
      // Subtraction is A + ~B + ~borrow, so the carry-in is flipped along with B.
      a_q     <= A;
      b_q     <= B ^ {WIDTH{sub}};
      carry_q <= C_1 ^ sub;
      k_q     <= '0;
    end else if (state_q == BUSY) begin
      sum_q   <= sum_d;
      carry_q <= sl_cout;
      k_q     <= k_q + 1'b1;
      if (last_slice) begin
        s_q  <= sum_d;
        co_q <= sl_cout;
`ifdef CHUNKED_ADDER_OVF_EN
        ov_q <= msb_cin ^ sl_cout;
`endif
      end
    end
  end

`ifdef CHUNKED_ADDER_OVF_EN
  assign OV = ov_q;
`else
  assign OV = 1'b0;
`endif

endmodule
